// File: rtl/hash_round_sequencer_pkg.sv
// Shared opcode/decision encodings, sequencer state type and per-opcode loop-bound helpers.
package hash_round_sequencer_pkg;

  localparam logic [1:0] MD5            = 2'b00;
  localparam logic [1:0] SHA_1          = 2'b01;
  localparam logic [1:0] SHA_256        = 2'b10;
  localparam logic [1:0] DOUBLE_SHA_256 = 2'b11;

  localparam logic [1:0] WAIT     = 2'b00;
  localparam logic [1:0] CONTINUE = 2'b01;
  localparam logic [1:0] FINISH   = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

  // Double SHA-256 shares the SHA-256 bounds; callers pass the module parameters.
  function automatic int unsigned rounds_for(input logic [1:0] op, input int unsigned md5_n,
                                             input int unsigned sha1_n,
                                             input int unsigned sha256_n);
    case (op)
      MD5:     return md5_n;
      SHA_1:   return sha1_n;
      default: return sha256_n;
    endcase
  endfunction

  function automatic int unsigned steps_for(input logic [1:0] op, input int unsigned md5_n,
                                            input int unsigned sha1_n,
                                            input int unsigned sha256_n);
    case (op)
      MD5:     return md5_n;
      SHA_1:   return sha1_n;
      default: return sha256_n;
    endcase
  endfunction

endpackage

// File: rtl/hash_round_sequencer_round_step_counter.sv
// Nested step/round counter: step wraps into round, round wraps back to zero at block end.
module round_step_counter #(
  parameter int unsigned RoundW = 8,
  parameter int unsigned StepW  = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic [StepW-1:0]  last_step_val_i,
  input  logic [RoundW-1:0] last_round_val_i,
  output logic [StepW-1:0]  step_o,
  output logic [RoundW-1:0] round_o,
  output logic              last_step_o,
  output logic              last_round_o
);

  logic [StepW-1:0]  step_d, step_q;
  logic [RoundW-1:0] round_d, round_q;

  assign last_step_o  = (step_q == last_step_val_i);
  assign last_round_o = (round_q == last_round_val_i);
  assign step_o       = step_q;
  assign round_o      = round_q;

  always_comb begin
    step_d  = step_q;
    round_d = round_q;
    if (clr_i) begin
      step_d  = '0;
      round_d = '0;
    end else if (en_i) begin
      if (last_step_o) begin
        step_d  = '0;
        round_d = last_round_o ? '0 : round_q + 1'b1;
      end else begin
        step_d = step_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      step_q  <= '0;
      round_q <= '0;
    end else begin
      step_q  <= step_d;
      round_q <= round_d;
    end
  end

endmodule

// File: rtl/hash_round_sequencer.sv
// Step/round/block/pass sequencer for MD5, SHA-1, SHA-256 and double SHA-256 compression.
module hash_round_sequencer
  import hash_round_sequencer_pkg::*;
#(
  parameter int unsigned ROUND_W       = 8,
  parameter int unsigned STEP_W        = 6,
  parameter int unsigned BLK_W         = 16,
  parameter int unsigned MD5_ROUNDS    = 4,
  parameter int unsigned MD5_STEPS     = 16,
  parameter int unsigned SHA1_ROUNDS   = 5,
  parameter int unsigned SHA1_STEPS    = 16,
  parameter int unsigned SHA256_ROUNDS = 8,
  parameter int unsigned SHA256_STEPS  = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         opcode,
  input  logic [BLK_W-1:0]   num_blocks,
  input  logic               stall,
  input  logic               abort,
  output logic               busy,
  output logic               step_en,
  output logic               init_block,
  output logic [ROUND_W-1:0] round_idx,
  output logic [STEP_W-1:0]  step_idx,
  output logic [BLK_W-1:0]   block_idx,
  output logic               pass_idx,
  output logic               block_done,
  output logic               done,
  output logic [1:0]         decision
);

  localparam int unsigned MaxRounds1 = (MD5_ROUNDS > SHA1_ROUNDS) ? MD5_ROUNDS : SHA1_ROUNDS;
  localparam int unsigned MaxRounds  = (MaxRounds1 > SHA256_ROUNDS) ? MaxRounds1 : SHA256_ROUNDS;
  localparam int unsigned MaxSteps1  = (MD5_STEPS > SHA1_STEPS) ? MD5_STEPS : SHA1_STEPS;
  localparam int unsigned MaxSteps   = (MaxSteps1 > SHA256_STEPS) ? MaxSteps1 : SHA256_STEPS;

  if ((MaxRounds - 1) >= (1 << ROUND_W)) begin : g_round_w_chk
    $error("ROUND_W too narrow for the largest round count");
  end
  if ((MaxSteps - 1) >= (1 << STEP_W)) begin : g_step_w_chk
    $error("STEP_W too narrow for the largest step count");
  end

  seq_state_t       state_q;
  logic [1:0]       op_q;
  logic [BLK_W-1:0] nblk_q, blk_q;
  logic             pass_q;

  logic               run, cnt_clr, last_step, last_round, last_blk;
  logic [ROUND_W-1:0] last_round_val;
  logic [STEP_W-1:0]  last_step_val;

  assign last_round_val = ROUND_W'(rounds_for(op_q, MD5_ROUNDS, SHA1_ROUNDS, SHA256_ROUNDS) - 1);
  assign last_step_val  = STEP_W'(steps_for(op_q, MD5_STEPS, SHA1_STEPS, SHA256_STEPS) - 1);

  assign run      = (state_q == RUN);
  assign step_en  = run && !stall && !abort;
  assign cnt_clr  = ((state_q == IDLE) && start) || (run && abort);
  assign last_blk = (blk_q == nblk_q - 1'b1);

  round_step_counter #(
    .RoundW (ROUND_W),
    .StepW  (STEP_W)
  ) u_counter (
    .clk_i            (clk),
    .rst_ni           (reset_n),
    .en_i             (step_en),
    .clr_i            (cnt_clr),
    .last_step_val_i  (last_step_val),
    .last_round_val_i (last_round_val),
    .step_o           (step_idx),
    .round_o          (round_idx),
    .last_step_o      (last_step),
    .last_round_o     (last_round)
  );

  assign block_done = step_en && last_step && last_round;
  assign init_block = step_en && (step_idx == '0) && (round_idx == '0);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign block_idx  = blk_q;
  assign pass_idx   = pass_q;
  assign decision   = run ? (last_round ? FINISH : CONTINUE) : WAIT;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      nblk_q  <= '0;
      blk_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= opcode;
            nblk_q  <= (num_blocks == '0) ? BLK_W'(1) : num_blocks;
            blk_q   <= '0;
            pass_q  <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            blk_q   <= '0;
            pass_q  <= 1'b0;
            state_q <= IDLE;
          end else if (block_done) begin
            if (!last_blk) begin
              blk_q <= blk_q + 1'b1;
            end else if ((op_q == DOUBLE_SHA_256) && !pass_q) begin
              // Second pass hashes the single 256-bit digest block.
              pass_q <= 1'b1;
              blk_q  <= '0;
              nblk_q <= BLK_W'(1);
            end else begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          blk_q   <= '0;
          pass_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_round_sequencer.sv
// Scoreboard bench: runs push expected step/done records, a negedge monitor pops and compares.
module tb_hash_round_sequencer;

  localparam logic [1:0] OpMd5 = 2'b00, OpSha1 = 2'b01, OpSha256 = 2'b10, OpDbl = 2'b11;
  localparam logic [1:0] DecWait = 2'b00, DecCont = 2'b01, DecFin = 2'b10;

  logic        clk = 1'b0;
  logic        reset_n, start, stall, abort;
  logic [1:0]  opcode;
  logic [15:0] num_blocks;
  logic        busy, step_en, init_block, pass_idx, block_done, done;
  logic [7:0]  round_idx;
  logic [5:0]  step_idx;
  logic [15:0] block_idx;
  logic [1:0]  decision;

  hash_round_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .opcode     (opcode),
    .num_blocks (num_blocks),
    .stall      (stall),
    .abort      (abort),
    .busy       (busy),
    .step_en    (step_en),
    .init_block (init_block),
    .round_idx  (round_idx),
    .step_idx   (step_idx),
    .block_idx  (block_idx),
    .pass_idx   (pass_idx),
    .block_done (block_done),
    .done       (done),
    .decision   (decision)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_done;
    int          cyc;
    logic [5:0]  st;
    logic [7:0]  rd;
    logic [15:0] blk;
    logic        ps;
    logic        init;
    logic        bd;
    logic [1:0]  dec;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int rounds_of(input logic [1:0] op);
    return (op == OpMd5) ? 4 : (op == OpSha1) ? 5 : 8;
  endfunction

  function automatic int steps_of(input logic [1:0] op);
    return (op == OpMd5 || op == OpSha1) ? 16 : 8;
  endfunction

  // Reference sequence: steps in cycles after start, skipping stalled cycles, cut at kill.
  task automatic push_run(input logic [1:0] op, input int nb, input int t0, input int slo,
                          input int shi, input int kill);
    int r_n, s_n, c, nbp;
    exp_t e;
    r_n = rounds_of(op);
    s_n = steps_of(op);
    c   = t0 + 1;
    for (int p = 0; p < ((op == OpDbl) ? 2 : 1); p++) begin
      nbp = (p == 1) ? 1 : ((nb == 0) ? 1 : nb);
      for (int b = 0; b < nbp; b++)
        for (int r = 0; r < r_n; r++)
          for (int s = 0; s < s_n; s++) begin
            while (c >= t0 + slo && c <= t0 + shi) c++;
            if (kill != 0 && c >= t0 + kill) return;
            e.is_done = 1'b0;
            e.cyc     = c;
            e.st      = 6'(s);
            e.rd      = 8'(r);
            e.blk     = 16'(b);
            e.ps      = p[0];
            e.init    = (s == 0 && r == 0);
            e.bd      = (s == s_n - 1 && r == r_n - 1);
            e.dec     = (r == r_n - 1) ? DecFin : DecCont;
            q.push_back(e);
            c++;
          end
    end
    e = '{is_done: 1'b1, cyc: c, st: '0, rd: '0, blk: '0, ps: 1'b0, init: 1'b0, bd: 1'b0,
          dec: DecWait};
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (step_en === 1'b1 || done === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output cyc=%0d step_en=%b done=%b required=none",
                 cyc, step_en, done);
      end else begin
        me = q.pop_front();
        if (me.is_done) begin
          if (!(done === 1'b1 && step_en === 1'b0 && busy === 1'b1 && decision === DecWait &&
                cyc == me.cyc)) begin
            bad++;
            $display("FAIL done_pulse actual cyc=%0d done=%b step_en=%b busy=%b dec=%0d required cyc=%0d done=1 step_en=0 busy=1 dec=0",
                     cyc, done, step_en, busy, decision, me.cyc);
          end
        end else if (!(step_en === 1'b1 && done === 1'b0 && busy === 1'b1 && cyc == me.cyc &&
                       step_idx === me.st && round_idx === me.rd && block_idx === me.blk &&
                       pass_idx === me.ps && init_block === me.init &&
                       block_done === me.bd && decision === me.dec)) begin
          bad++;
          $display("FAIL step_record actual cyc=%0d en=%b st=%0d rd=%0d blk=%0d ps=%b init=%b bd=%b dec=%0d required cyc=%0d st=%0d rd=%0d blk=%0d ps=%b init=%b bd=%b dec=%0d",
                   cyc, step_en, step_idx, round_idx, block_idx, pass_idx, init_block,
                   block_done, decision, me.cyc, me.st, me.rd, me.blk, me.ps, me.init, me.bd,
                   me.dec);
        end
      end
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_step_en"}, 32'(step_en), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_step_idx"}, 32'(step_idx), 0);
    check({tag, "_round_idx"}, 32'(round_idx), 0);
    check({tag, "_block_idx"}, 32'(block_idx), 0);
    check({tag, "_pass_idx"}, 32'(pass_idx), 0);
    check({tag, "_decision"}, 32'(decision), 32'(DecWait));
  endtask

  // kill>0: abort (or reset when kill_rst) in that cycle relative to start; ign_k: stray start.
  task automatic do_run(input logic [1:0] op, input int nb, input int slo, input int shi,
                        input int kill, input bit kill_rst, input int ign_k);
    int s, n, blocks, last_k;
    s      = cyc;
    blocks = ((nb == 0) ? 1 : nb) + ((op == OpDbl) ? 1 : 0);
    n      = 1 + blocks * rounds_of(op) * steps_of(op) + ((slo > 0) ? (shi - slo + 1) : 0);
    last_k = (kill != 0) ? kill : n;
    push_run(op, nb, s, slo, shi, kill);
    start      = 1'b1;
    opcode     = op;
    num_blocks = 16'(nb);
    @(posedge clk);
    #1;
    for (int k = 1; k <= last_k; k++) begin
      stall = (k >= slo && k <= shi);
      abort = (!kill_rst && kill == k);
      if (k == ign_k) begin
        start      = 1'b1;
        opcode     = OpMd5;
        num_blocks = 16'd5;
      end else begin
        start = 1'b0;
      end
      if (slo == 10 && k == 12) begin
        #1;
        check("stall_step_en", 32'(step_en), 0);
        check("stall_step_hold", 32'(step_idx), 1);
        check("stall_round_hold", 32'(round_idx), 1);
        check("stall_decision", 32'(decision), 32'(DecCont));
      end
      if (kill_rst && k == kill) begin
        reset_n = 1'b0;
        #1;
        check_idle("midrun_reset");
      end
      @(posedge clk);
      #1;
    end
    stall   = 1'b0;
    abort   = 1'b0;
    start   = 1'b0;
    reset_n = 1'b1;
    if (kill != 0 && !kill_rst) check_idle("after_abort");
    else if (kill == 0) check("busy_low_after_done", 32'(busy), 0);
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    stall      = 1'b0;
    abort      = 1'b0;
    opcode     = 2'b00;
    num_blocks = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    do_run(OpMd5, 1, -1, -1, 0, 1'b0, 0);
    do_run(OpSha1, 3, -1, -1, 0, 1'b0, 50);
    do_run(OpDbl, 2, -1, -1, 0, 1'b0, 0);
    do_run(OpSha256, 1, 10, 14, 0, 1'b0, 0);
    do_run(OpSha256, 1, 20, 20, 20, 1'b0, 0);
    do_run(OpSha256, 1, -1, -1, 30, 1'b1, 0);
    do_run(OpSha256, 0, -1, -1, 0, 1'b0, 0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hash_round_sequencer.md
Name: hash_round_sequencer

Overview:
- Sequential successor to the combinational end-of-round decoder used by the hash datapath.
- Owns the step, round, block and pass counters for MD5, SHA-1, SHA-256 and double-SHA-256 (opcode 2'b11).
- Drives step enables to the compression core and keeps the legacy WAIT/CONTINUE/FINISH decision output.
- Sits between the message-block loader and the hash datapath, with a start/done handshake, stall and abort.

Parameters:
- ROUND_W, 8: width of round_idx.
- STEP_W, 6: width of step_idx.
- BLK_W, 16: width of the block count and block index.
- MD5_ROUNDS, 4; MD5_STEPS, 16: MD5 rounds per block, steps per round.
- SHA1_ROUNDS, 5; SHA1_STEPS, 16: SHA-1 rounds per block, steps per round.
- SHA256_ROUNDS, 8; SHA256_STEPS, 8: SHA-256 rounds per block, steps per round. Opcode 2'b11 uses these too.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new hash; sampled only in IDLE.
- opcode  in  2  MD5/SHA_1/SHA_256/2'b11 (double SHA-256); latched on accepted start.
- num_blocks  in  BLK_W  message blocks; latched on start; 0 is treated as 1.
- stall  in  1  hold all counters for this cycle.
- abort  in  1  synchronous cancel.
- busy  out  1  high in RUN and DONE.
- step_en  out  1  datapath performs one step this cycle.
- init_block  out  1  step_en on step 0 of round 0; datapath loads the chaining value.
- round_idx  out  ROUND_W  current round.
- step_idx  out  STEP_W  current step within the round.
- block_idx  out  BLK_W  current block.
- pass_idx  out  1  0 = first pass, 1 = second SHA-256 pass (opcode 2'b11 only).
- block_done  out  1  step_en on the final step of the final round of a block.
- done  out  1  one-cycle completion pulse.
- decision  out  2  WAIT / CONTINUE / FINISH.

Behaviour:
- Reset (async, reset_n low): state IDLE; all counters, pass_idx, latched opcode and num_blocks are 0; busy, step_en, done are 0; decision=WAIT. Reset mid-RUN discards the operation with no done.
- States: IDLE, RUN, DONE.
- IDLE: start=1 latches opcode and max(num_blocks,1), clears counters, moves to RUN. start is ignored in RUN and DONE.
- RUN: step_en = !stall && !abort, combinational.
  - On each step_en: step_idx increments.
  - At the last step: step_idx returns to 0 and round_idx increments.
  - At the last round: round_idx returns to 0 and block_idx increments.
- End of last block:
  - opcode 2'b11 with pass_idx=0: pass_idx becomes 1, block_idx=0, block count forced to 1, stay in RUN.
  - Any other case: go to DONE.
- DONE lasts exactly one cycle: done=1, busy=1, step_en=0. Then IDLE; the earliest new start is the following cycle.
- stall=1: counters and state hold; step_en=0; decision holds its RUN value.
- abort=1 in RUN: wins over stall and step completion; next state IDLE, counters cleared, no done. abort is ignored in IDLE and DONE.
- decision:
  - WAIT in IDLE and DONE.
  - In RUN, FINISH when round_idx equals the final round for the opcode, otherwise CONTINUE.
- Latency (no stall): start accepted at cycle 0; first step_en at cycle 1; done = 1 + B*R*S cycles after start.
  - B = blocks, R = rounds per block, S = steps per round.
  - Opcode 2'b11 adds one extra block.
- Counter widths are checked by elaboration assertions: rounds-1 must fit in ROUND_W and steps-1 in STEP_W.

Decomposition:
- Add to the Definitions package:
  - seq_state_t enum {IDLE, RUN, DONE}.
  - Helper functions rounds_for(opcode) and steps_for(opcode), driven by the parameters.
  - The DOUBLE_SHA_256 = 2'b11 constant.
- Reuse the existing opcode and decision constants from Definitions.
- One sub-module: round_step_counter.
  - Nested step/round counter with enable, clear and last-step/last-round flags.
  - Instantiated once; the block and pass logic stays in the top level.

Test Plan:
- MD5, num_blocks=1, no stall, start at cycle 0 -> 64 step_en cycles (1..64); block_done at 64; done at 65; decision FINISH from round_idx=3; busy low at 66.
- SHA_1, num_blocks=3 -> 240 steps; block_idx 0→1→2; init_block pulses at cycles 1, 81, 161; done at 241.
- Opcode 2'b11, num_blocks=2 -> pass 0 takes 128 steps; pass_idx=1 for 64 more steps, block_idx=0; done at 193.
- SHA_256, num_blocks=0 -> treated as 1 block; done at 65.
- SHA_256 with stall high for cycles 10–14 -> step_idx frozen during the stall; done delayed by 5 (cycle 70).
- SHA_256 abort at cycle 20 (with stall also high), and separately reset_n low at cycle 30 -> IDLE next cycle / immediately, counters 0, no done; new start accepted afterwards; start during RUN ignored.
